caliptra_apb_txn_driver: RTL and testbench
==========================================

# caliptra_apb_txn_driver

Single-outstanding APB master that turns simple valid/ready request/response transactions from the simulation harness into protocol-correct APB SETUP/ACCESS sequences on the Caliptra SoC-side APB port. It sits directly upstream of the Verilated Caliptra top, driving its `paddr/psel/penable/pwrite/pwdata/pauser/pprot` inputs and consuming `pready/prdata/pslverr`. This replaces per-cycle pin wiggling in C++ with one request per access and adds a hang timeout.

## Interface
Parameters:
- `ADDR_W`, default `CALIPTRA_APB_ADDR_WIDTH`: APB address width.
- `DATA_W`, default `CALIPTRA_APB_DATA_WIDTH`: APB data width.
- `USER_W`, default `CALIPTRA_APB_USER_WIDTH`: PAUSER width.
- `TIMEOUT_CYCLES`, default 1024: maximum ACCESS-phase cycles before abort; legal range 2..65535.

Ports:
- `core_clk` input 1: clock.
- `cptra_rst_b` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: request accepted this cycle when both high.
- `req_write` input 1: 1 write, 0 read.
- `req_addr` input ADDR_W: target address.
- `req_wdata` input DATA_W: write data, ignored for reads.
- `req_user` input USER_W: PAUSER value.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: response consumed when both high.
- `rsp_rdata` output DATA_W: read data; 0 for writes.
- `rsp_slverr` output 1: PSLVERR sampled, or timeout.
- `rsp_timeout` output 1: ACCESS phase aborted.
- `paddr` output ADDR_W, `pwrite` output 1, `pwdata` output DATA_W, `pauser` output USER_W, `pprot` output 3 (constant 0), `psel` output 1, `penable` output 1: APB request.
- `pready` input 1, `prdata` input DATA_W, `pslverr` input 1: APB completion.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch addr/write/wdata/user into holding registers → SETUP.
- SETUP: `psel`=1, `penable`=0, APB outputs driven from holding registers → ACCESS unconditionally.
- ACCESS: `psel`=1, `penable`=1. On `pready`=1: capture `prdata` (reads only; writes capture 0) and `pslverr`, `rsp_timeout`=0 → RESP. Otherwise increment the 16-bit wait counter; when counter == TIMEOUT_CYCLES-1 with `pready`=0 → RESP with `rsp_rdata`=32'hDEAD_DEAD (reads; 0 for writes), `rsp_slverr`=1, `rsp_timeout`=1.
- RESP: `rsp_valid`=1, `psel`=`penable`=0, response held stable until `rsp_ready`. `req_ready` = `rsp_ready` in RESP: a simultaneous `rsp_ready` and `req_valid` retires the response and latches the new request → SETUP (back-to-back). `rsp_ready` without `req_valid` → IDLE.
- `paddr/pwrite/pwdata/pauser` hold the last transaction's values outside SETUP/ACCESS (no X, no toggling).
- `pready` and `pslverr` ignored outside ACCESS.
- Wait counter cleared on entry to SETUP.

## Timing
- Reset (asynchronous assertion, synchronous release): state IDLE; `req_ready`=1 after reset is released, 0 during reset; all other outputs 0; counter 0.
- Reset mid-transaction: `psel`/`penable`/`rsp_valid` drop immediately; the transaction is lost with no response.
- Request accepted at edge T → `psel` at T+1, `penable` at T+2. If `pready`=1 at T+2, `rsp_valid` at T+3. Minimum 3 cycles per transaction back-to-back.
- Timeout: `rsp_valid` asserts exactly TIMEOUT_CYCLES cycles after ACCESS entry.
- All outputs registered; no combinational path from `pready`/`prdata` to any output.

## Structure
- Shared package `caliptra_apb_drv_pkg`: FSM state enum (`APB_DRV_IDLE`, `APB_DRV_SETUP`, `APB_DRV_ACCESS`, `APB_DRV_RESP`) and `APB_DRV_TIMEOUT_RDATA` = 32'hDEAD_DEAD.
- Single flat module; no sub-module. The wrapper instantiates it ahead of `caliptra_top` and exposes the req/rsp ports to C++.

## Test plan
- Read, zero wait: req addr 0x3003_0000, `pready` in first ACCESS cycle, `prdata`=0x1234_5678 → `psel` T+1, `penable` T+2, `rsp_valid` T+3, `rsp_rdata`=0x1234_5678, slverr=0, timeout=0.
- Write with 5 wait states: addr 0x3003_0010, wdata 0xA5A5_A5A5, user 0xFFFF_FFFF, `pready` after 5 ACCESS cycles → APB fields stable throughout ACCESS, `rsp_rdata`=0, one response.
- Slave error: read with `pslverr`=1 at `pready` → `rsp_slverr`=1, `rsp_timeout`=0.
- Timeout: TIMEOUT_CYCLES=16, `pready` never asserts → `rsp_valid` exactly 16 cycles after ACCESS entry, rdata 0xDEAD_DEAD, slverr=1, timeout=1; `psel` low in RESP.
- Backpressure and back-to-back: hold `rsp_ready`=0 for 10 cycles → response stable, `req_ready`=0; then `rsp_ready`=1 with `req_valid`=1 → new SETUP on next cycle, with no idle gap.
- Reset in ACCESS: deassert `cptra_rst_b` mid-wait → `psel`/`penable`/`rsp_valid` 0 immediately; after release, `req_ready`=1 and the next transaction completes normally.

Source files
------------

// File: rtl/caliptra_apb_drv_pkg.sv
// Shared types and constants for the single-outstanding APB transaction driver.
package caliptra_apb_drv_pkg;

  localparam int unsigned CALIPTRA_APB_ADDR_WIDTH = 32;
  localparam int unsigned CALIPTRA_APB_DATA_WIDTH = 32;
  localparam int unsigned CALIPTRA_APB_USER_WIDTH = 32;

  localparam logic [31:0] APB_DRV_TIMEOUT_RDATA = 32'hDEAD_DEAD;

  typedef enum logic [1:0] {
    APB_DRV_IDLE,
    APB_DRV_SETUP,
    APB_DRV_ACCESS,
    APB_DRV_RESP
  } apb_drv_state_e;

endpackage

// File: rtl/caliptra_apb_txn_driver.sv
// APB master converting valid/ready request/response transactions into
// SETUP/ACCESS sequences, with an ACCESS-phase hang timeout.
module caliptra_apb_txn_driver
  import caliptra_apb_drv_pkg::*;
#(
  parameter int unsigned ADDR_W         = CALIPTRA_APB_ADDR_WIDTH,
  parameter int unsigned DATA_W         = CALIPTRA_APB_DATA_WIDTH,
  parameter int unsigned USER_W         = CALIPTRA_APB_USER_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              core_clk,
  input  logic              cptra_rst_b,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [USER_W-1:0] req_user,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  output logic [USER_W-1:0] pauser,
  output logic [2:0]        pprot,
  output logic              psel,
  output logic              penable,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pslverr
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  apb_drv_state_e state_q, state_d;
  logic [15:0]    wait_cnt_q;
  logic           accept;
  logic           access_timeout;

  assign pprot  = '0;
  assign accept = req_valid && req_ready;

  always_comb begin
    state_d        = state_q;
    req_ready      = 1'b0;
    psel           = 1'b0;
    penable        = 1'b0;
    rsp_valid      = 1'b0;
    access_timeout = 1'b0;
    unique case (state_q)
      APB_DRV_IDLE: begin
        // Gated by reset so req_ready reads 0 while reset is held.
        req_ready = cptra_rst_b;
        if (req_valid && cptra_rst_b) state_d = APB_DRV_SETUP;
      end
      APB_DRV_SETUP: begin
        psel    = 1'b1;
        state_d = APB_DRV_ACCESS;
      end
      APB_DRV_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) begin
          state_d = APB_DRV_RESP;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          access_timeout = 1'b1;
          state_d        = APB_DRV_RESP;
        end
      end
      APB_DRV_RESP: begin
        rsp_valid = 1'b1;
        req_ready = rsp_ready;
        if (rsp_ready) state_d = req_valid ? APB_DRV_SETUP : APB_DRV_IDLE;
      end
      default: state_d = APB_DRV_IDLE;
    endcase
  end

  always_ff @(posedge core_clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      state_q     <= APB_DRV_IDLE;
      wait_cnt_q  <= '0;
      paddr       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      pauser      <= '0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        paddr      <= req_addr;
        pwrite     <= req_write;
        pwdata     <= req_wdata;
        pauser     <= req_user;
        wait_cnt_q <= '0;
      end else if (state_q == APB_DRV_ACCESS && !pready) begin
        wait_cnt_q <= wait_cnt_q + 16'd1;
      end
      if (state_q == APB_DRV_ACCESS) begin
        if (pready) begin
          rsp_rdata   <= pwrite ? '0 : prdata;
          rsp_slverr  <= pslverr;
          rsp_timeout <= 1'b0;
        end else if (access_timeout) begin
          rsp_rdata   <= pwrite ? '0 : DATA_W'(APB_DRV_TIMEOUT_RDATA);
          rsp_slverr  <= 1'b1;
          rsp_timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_caliptra_apb_txn_driver.sv
// Table-driven bench for caliptra_apb_txn_driver with an APB slave model and
// a response scoreboard.
module tb_caliptra_apb_txn_driver;

  localparam int unsigned TO = 16;

  logic        core_clk = 1'b0;
  logic        cptra_rst_b = 1'b0;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata, req_user;
  logic        rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, pauser, prdata;
  logic        pwrite, psel, penable, pready, pslverr;
  logic [2:0]  pprot;

  always #5 core_clk = ~core_clk;

  caliptra_apb_txn_driver #(
    .ADDR_W(32), .DATA_W(32), .USER_W(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .core_clk(core_clk), .cptra_rst_b(cptra_rst_b),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_user(req_user),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pauser(pauser),
    .pprot(pprot), .psel(psel), .penable(penable),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  typedef struct {
    logic        write;
    logic [31:0] addr, wdata, user;
    int          waits;
    logic [31:0] prdata;
    logic        pslverr;
    logic [31:0] exp_rdata;
    logic        exp_slverr, exp_timeout;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        slverr, timeout;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  int          cur_waits = 1000;
  logic [31:0] cur_prdata = '0, cur_addr = '0, cur_wdata = '0, cur_user = '0;
  logic        cur_pslverr = 1'b0, cur_write = 1'b0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] u, input int waits, input logic [31:0] prd,
                              input logic err, input logic [31:0] er, input logic es,
                              input logic et, input int lat);
    vec_t v;
    v.write = w; v.addr = a; v.wdata = wd; v.user = u; v.waits = waits;
    v.prdata = prd; v.pslverr = err; v.exp_rdata = er; v.exp_slverr = es;
    v.exp_timeout = et; v.exp_lat = lat;
    return v;
  endfunction

  // APB slave: pready after cur_waits ACCESS cycles; random noise elsewhere.
  initial begin
    int acc;
    acc = 0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    forever begin
      @(posedge core_clk); #1;
      if (psel && penable) begin
        if (acc == cur_waits) begin
          pready = 1'b1; prdata = cur_prdata; pslverr = cur_pslverr;
        end else begin
          pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
        end
        acc++;
      end else begin
        acc = 0; pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
      end
    end
  end

  // APB request-side observer.
  initial begin
    bit prev_sel;
    prev_sel = 1'b0;
    forever begin
      @(negedge core_clk);
      if (psel) begin
        chk(paddr == cur_addr && pwrite == cur_write && pwdata == cur_wdata &&
            pauser == cur_user && pprot == 3'd0, "apb_fields", paddr, cur_addr);
        if (penable) chk(prev_sel, "penable_after_setup", 32'(prev_sel), 32'd1);
      end
      prev_sel = psel;
    end
  end

  // Response scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge core_clk);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_rsp", rsp_rdata, 32'd0);
        end else begin
          e = sb.pop_front();
          chk(rsp_rdata == e.rdata, "rsp_rdata", rsp_rdata, e.rdata);
          chk(rsp_slverr == e.slverr, "rsp_slverr", 32'(rsp_slverr), 32'(e.slverr));
          chk(rsp_timeout == e.timeout, "rsp_timeout", 32'(rsp_timeout), 32'(e.timeout));
          chk(!psel && !penable, "apb_idle_in_resp", 32'({psel, penable}), 32'd0);
        end
      end
    end
  end

  task automatic set_req(input vec_t v);
    req_write = v.write; req_addr = v.addr; req_wdata = v.wdata; req_user = v.user;
    req_valid = 1'b1;
    cur_write = v.write; cur_addr = v.addr; cur_wdata = v.wdata; cur_user = v.user;
    cur_waits = v.waits; cur_prdata = v.prdata; cur_pslverr = v.pslverr;
  endtask

  task automatic drive_req(input vec_t v);
    int n;
    n = 0;
    @(posedge core_clk); #1;
    set_req(v);
    @(negedge core_clk);
    while (!req_ready && n < 50) begin
      @(negedge core_clk);
      n++;
    end
    chk(req_ready, "req_accept", 32'(req_ready), 32'd1);
    @(posedge core_clk);
    sb.push_back('{rdata: v.exp_rdata, slverr: v.exp_slverr, timeout: v.exp_timeout});
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int exp_lat);
    int lat;
    lat = 0;
    do begin
      @(negedge core_clk);
      lat++;
      if (lat == 1) chk(psel && !penable, "setup_phase", 32'({psel, penable}), 32'd2);
      if (lat == 2) chk(psel && penable, "access_phase", 32'({psel, penable}), 32'd3);
    end while (!rsp_valid && lat < 100);
    chk(lat == exp_lat, "rsp_latency", 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t bp, b2b, lost;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_user = '0;
    rsp_ready = 1'b1;

    //            w  addr          wdata         user          waits prdata        err exp_rdata     es et lat
    vecs[0] = mk(0, 32'h3003_0000, 32'h0,        32'h0000_0001, 0,   32'h1234_5678, 0, 32'h1234_5678, 0, 0, 3);
    vecs[1] = mk(1, 32'h3003_0010, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 5,   32'hCAFE_BABE, 0, 32'h0,        0, 0, 8);
    vecs[2] = mk(0, 32'h3003_0020, 32'h1111_1111, 32'h0000_00AA, 2,   32'h0BAD_F00D, 1, 32'h0BAD_F00D, 1, 0, 5);
    vecs[3] = mk(0, 32'h3003_0030, 32'h0,        32'h0000_0002, 1000, 32'h0,        0, 32'hDEAD_DEAD, 1, 1, 18);
    vecs[4] = mk(1, 32'h3003_0034, 32'h5A5A_0F0F, 32'h0000_0003, 1000, 32'h0,        0, 32'h0,        1, 1, 18);
    vecs[5] = mk(0, 32'h3003_0038, 32'h0,        32'h0000_0004, 15,  32'h5555_AAAA, 0, 32'h5555_AAAA, 0, 0, 18);
    vecs[6] = mk(1, 32'h3003_003C, 32'h0000_0001, 32'h8000_0000, 1,   32'h7654_3210, 1, 32'h0,        1, 0, 4);
    vecs[7] = mk(0, 32'hFFFF_FFFC, 32'h0,        32'h0,        0,   32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 0, 0, 3);
    bp   = mk(0, 32'h3003_0040, 32'h0,        32'h0000_0005, 1,   32'h7777_1111, 0, 32'h7777_1111, 0, 0, 4);
    b2b  = mk(1, 32'h3003_0044, 32'hC3C3_3C3C, 32'h0000_0006, 0,   32'h9999_9999, 0, 32'h0,        0, 0, 3);
    lost = mk(0, 32'h3003_0048, 32'h0,        32'h0000_0007, 1000, 32'h0,        0, 32'h0,        0, 0, 0);

    #12;
    chk(!req_ready, "req_ready_in_reset", 32'(req_ready), 32'd0);
    chk(!psel && !penable && !rsp_valid && !rsp_slverr && !rsp_timeout && !pwrite &&
        rsp_rdata == 32'd0 && paddr == 32'd0 && pwdata == 32'd0 && pauser == 32'd0 &&
        pprot == 3'd0, "reset_outputs", paddr | pwdata | pauser | rsp_rdata, 32'd0);
    #10 cptra_rst_b = 1'b1;
    @(negedge core_clk);
    chk(req_ready, "req_ready_after_reset", 32'(req_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      drive_req(vecs[i]);
      wait_rsp(vecs[i].exp_lat);
    end

    // Backpressure, then back-to-back retire-and-accept.
    @(posedge core_clk); #1 rsp_ready = 1'b0;
    drive_req(bp);
    wait_rsp(bp.exp_lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge core_clk);
      chk(rsp_valid && !req_ready && !psel && rsp_rdata == 32'h7777_1111 && !rsp_slverr,
          "bp_hold", rsp_rdata, 32'h7777_1111);
    end
    @(posedge core_clk); #1;
    rsp_ready = 1'b1;
    set_req(b2b);
    @(negedge core_clk);
    chk(req_ready, "b2b_req_ready", 32'(req_ready), 32'd1);
    @(posedge core_clk);
    sb.push_back('{rdata: b2b.exp_rdata, slverr: b2b.exp_slverr, timeout: b2b.exp_timeout});
    #1 req_valid = 1'b0;
    wait_rsp(b2b.exp_lat);

    // Reset while waiting in ACCESS: transaction dropped, no response.
    drive_req(lost);
    repeat (4) @(negedge core_clk);
    #2 cptra_rst_b = 1'b0;
    #1 chk(!psel && !penable && !rsp_valid && !req_ready, "reset_mid_access",
           32'({psel, penable, rsp_valid, req_ready}), 32'd0);
    sb.delete();
    @(posedge core_clk); #3 cptra_rst_b = 1'b1;
    @(negedge core_clk);
    chk(req_ready, "req_ready_after_rst2", 32'(req_ready), 32'd1);
    drive_req(vecs[0]);
    wait_rsp(vecs[0].exp_lat);

    repeat (3) @(negedge core_clk);
    chk(sb.size() == 0, "scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
